// File: rtl/seven_seg_scan.sv
// Time-multiplexed 3-digit seven-segment driver with frame-synchronous double buffering,
// per-digit blanking and anode dead time; outputs are registered one cycle after the scan state.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [2:0] blank,
    input  logic       load,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic            pend;
    logic [2:0][3:0] pend_d;
    logic [2:0]      pend_blank;
    logic [2:0][3:0] act_d;
    logic [2:0]      act_blank;

    logic       wrap;
    logic       boundary;
    logic [3:0] cur_d;
    logic       cur_blank;
    logic       dark;
    logic [6:0] nxt_seg;
    logic [2:0] nxt_an;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
    assign boundary = wrap && (idx == 2'd2);

    always_comb begin
        cur_d     = 4'h0;
        cur_blank = 1'b1;
        case (idx)
            2'd0: begin cur_d = act_d[0]; cur_blank = act_blank[0]; end
            2'd1: begin cur_d = act_d[1]; cur_blank = act_blank[1]; end
            2'd2: begin cur_d = act_d[2]; cur_blank = act_blank[2]; end
            default: begin cur_d = 4'h0; cur_blank = 1'b1; end
        endcase
        dark    = (cnt < CW'(DEAD_CYC)) || cur_blank;
        nxt_seg = dark ? 7'h7F : decode(cur_d);
        nxt_an  = dark ? 3'b111 : ~(3'b001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pend       <= 1'b0;
            pend_d     <= '0;
            pend_blank <= 3'b000;
            act_d      <= '0;
            act_blank  <= 3'b111;
            seg        <= 7'h7F;
            an         <= 3'b111;
            frame      <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            frame <= boundary;
            seg   <= nxt_seg;
            an    <= nxt_an;

            // Active copy takes the pre-edge pending contents; a same-edge load stays pending.
            if (boundary && pend) begin
                act_d     <= pend_d;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_d     <= {d2, d1, d0};
                pend_blank <= blank;
                pend       <= 1'b1;
            end else if (boundary) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=8, DEAD_CYC=2 (24-cycle frame).
module tb_seven_seg_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d0 = 4'h0, d1 = 4'h0, d2 = 4'h0;
    logic [2:0] blank = 3'b000;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    int cyc = 0;
    int passed = 0;
    int total = 0;

    seven_seg_scan #(.REFRESH_DIV(8), .DEAD_CYC(2)) dut (
        .clk(clk), .rst(rst), .d0(d0), .d1(d1), .d2(d2),
        .blank(blank), .load(load), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [2:0] bl);
        d0 = a; d1 = b; d2 = c; blank = bl; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c <= 72; c++) begin
            run_to(c);
            total++;
            if (an !== 3'b111 || seg !== 7'h7F || frame !== (c == 24 || c == 48 || c == 72))
                $display("FAIL reset_idle cyc=%0d an=%b seg=%b frame=%b exp an=111 seg=1111111 frame=%b",
                         c, an, seg, frame, (c == 24 || c == 48 || c == 72));
            else passed++;
        end
    endtask

    // Basic 1/8/F, then a mid-frame load of 0/0/0 that must wait for the cycle-48 frame.
    task automatic test_basic_and_tearing();
        logic [6:0] e_seg;
        logic [2:0] e_an;
        logic [3:0] v [3];
        int off;
        do_reset();
        run_to(5);
        do_load(4'h1, 4'h8, 4'hF, 3'b000);
        for (int c = 6; c <= 72; c++) begin
            if (c == 36) do_load(4'h0, 4'h0, 4'h0, 3'b000);
            run_to(c);
            e_seg = 7'h7F;
            e_an  = 3'b111;
            if (c > 24) begin
                off = (c > 48) ? c - 48 : c - 24;
                if (c > 48) begin v[0] = 4'h0; v[1] = 4'h0; v[2] = 4'h0; end
                else        begin v[0] = 4'h1; v[1] = 4'h8; v[2] = 4'hF; end
                for (int i = 0; i < 3; i++)
                    if (off >= 3 + 8 * i && off <= 8 + 8 * i) begin
                        e_an  = (i == 0) ? 3'b110 : (i == 1) ? 3'b101 : 3'b011;
                        e_seg = (v[i] == 4'h1) ? 7'b1111001 : (v[i] == 4'h8) ? 7'b0000000 :
                                (v[i] == 4'hF) ? 7'b0001110 : 7'b1000000;
                    end
            end
            total++;
            if (an !== e_an || seg !== e_seg || frame !== (c == 24 || c == 48 || c == 72))
                $display("FAIL basic_tearing cyc=%0d an=%b seg=%b frame=%b exp an=%b seg=%b",
                         c, an, seg, frame, e_an, e_seg);
            else passed++;
        end
    endtask

    task automatic test_blank();
        logic [6:0] e_seg;
        logic [2:0] e_an;
        int off;
        do_reset();
        run_to(1);
        do_load(4'h3, 4'h4, 4'h5, 3'b010);
        for (int c = 25; c <= 72; c++) begin
            run_to(c);
            off = (c > 48) ? c - 48 : c - 24;
            e_seg = 7'h7F;
            e_an  = 3'b111;
            if (off >= 3 && off <= 8)   begin e_an = 3'b110; e_seg = 7'b0110000; end
            if (off >= 19 && off <= 24) begin e_an = 3'b011; e_seg = 7'b0010010; end
            total++;
            if (an !== e_an || seg !== e_seg)
                $display("FAIL blank cyc=%0d an=%b seg=%b exp an=%b seg=%b", c, an, seg, e_an, e_seg);
            else passed++;
        end
    endtask

    task automatic test_boundary_load();
        logic [6:0] e_seg;
        logic [2:0] e_an;
        do_reset();
        run_to(5);
        do_load(4'hA, 4'h0, 4'h0, 3'b110);
        run_to(23);
        do_load(4'hC, 4'h0, 4'h0, 3'b110);
        for (int c = 24; c <= 72; c++) begin
            run_to(c);
            e_seg = 7'h7F;
            e_an  = 3'b111;
            if (c >= 27 && c <= 32) begin e_an = 3'b110; e_seg = 7'b0001000; end
            if (c >= 51 && c <= 56) begin e_an = 3'b110; e_seg = 7'b1000110; end
            total++;
            if (an !== e_an || seg !== e_seg)
                $display("FAIL boundary_load cyc=%0d an=%b seg=%b exp an=%b seg=%b", c, an, seg, e_an, e_seg);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        run_to(5);
        do_load(4'h1, 4'h8, 4'hF, 3'b000);
        run_to(36);
        total++;
        if (an !== 3'b101) $display("FAIL mid_pre cyc=36 an=%b exp 101", an);
        else passed++;
        rst = 1'b1;
        d0 = 4'h7; d1 = 4'h7; d2 = 4'h7; blank = 3'b000; load = 1'b1;
        tick();
        total++;
        if (an !== 3'b111 || seg !== 7'h7F || frame !== 1'b0)
            $display("FAIL mid_reset an=%b seg=%b frame=%b exp 111 1111111 0", an, seg, frame);
        else passed++;
        rst = 1'b0;
        load = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            total++;
            if (an !== 3'b111 || seg !== 7'h7F)
                $display("FAIL mid_after k=%0d an=%b seg=%b exp 111 1111111", k, an, seg);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_and_tearing();
        test_blank();
        test_boundary_load();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed 3-digit seven-segment display driver. It sits directly downstream of the core: it takes the three 4-bit display values (NOM, BIT zero-extended, EL) and drives the board's `seg`/`an` pins. Compared with a plain combinational decoder it adds three things: input double-buffering with frame-synchronous update (no tearing), per-digit blanking, and anode dead time between digit slots (no ghosting).

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 4.
- `DEAD_CYC`, default 500: cycles at the start of each slot during which all anodes are off; 1 ≤ `DEAD_CYC` < `REFRESH_DIV`.
- `clk`  in  1  clock, the divided `clk_reg` domain; single clock.
- `rst`  in  1  synchronous, active-high reset.
- `d0`  in  4  value for digit 0, driven on `an[0]`.
- `d1`  in  4  value for digit 1, driven on `an[1]`.
- `d2`  in  4  value for digit 2, driven on `an[2]`.
- `blank`  in  3  per-digit blank request; bit i = 1 blanks digit i.
- `load`  in  1  one-cycle strobe; captures `d0..d2` and `blank` into the pending buffer.
- `seg`  out  7  active-low segments, `seg[6:0]` = g f e d c b a.
- `an`  out  3  active-low anodes.
- `frame`  out  1  one-cycle pulse at the start of every scan frame.

## Operation
- **Counters.**
  - Slot counter `cnt` runs 0..`REFRESH_DIV`-1 and wraps to 0.
  - Digit index `idx` runs 0→1→2→0 and advances only when `cnt` wraps.
- **Pending buffer.**
  - `load`=1 writes `d0..d2` and `blank` into the pending registers and sets `pend`=1.
  - A later `load` before the next frame boundary overwrites the pending values; last one wins.
- **Frame boundary.** This is the edge at which `cnt`=`REFRESH_DIV`-1 and `idx`=2. At that edge:
  - `cnt`←0, `idx`←0, `frame`←1.
  - If `pend`=1: the active registers ← pending registers, and `pend`←0.
- **Load on the boundary edge.**
  - The active registers take the pending contents as they were *before* that edge.
  - The new load goes into pending, and `pend` ends at 1.
  - The new values are therefore applied at the following boundary.
- **Decode.** Hex, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
- **Output rule.** Registered, evaluated from the state in cycle t and visible in cycle t+1.
  - Digit i is dark if `cnt` < `DEAD_CYC` OR active blank[i]=1. Dark means `an`=111 and `seg`=1111111.
  - Otherwise `an` = ~(3'b001 << `idx`) and `seg` = decode(active d[`idx`]).
- **Reset** (any cycle with `rst`=1, including mid-scan):
  - `cnt`=0, `idx`=0, `pend`=0, pending/active digits = 0, active blank = 111.
  - Outputs: `an`=111, `seg`=1111111, `frame`=0.
  - `load` is ignored while `rst`=1.

## Timing
- Slot = `REFRESH_DIV` cycles; frame = 3·`REFRESH_DIV` cycles.
- Per slot: `DEAD_CYC` dark cycles, then `REFRESH_DIV`-`DEAD_CYC` lit cycles.
- `an`/`seg` lag the counter state by exactly 1 cycle.
- `frame` is high exactly in the cycle where `cnt`=0 and `idx`=0. The active registers already hold the new values in that cycle.
- Load-to-display latency:
  - Up to one frame + 1 + `DEAD_CYC` cycles before the first lit digit 0.
  - Never less than the remaining part of the current frame.
- After `rst` falls (first cycle with `rst`=0 counted as cycle 0):
  - The first `frame` pulse is in cycle 3·`REFRESH_DIV`.
  - All digits stay dark until a load is applied.
- `an` never has more than one bit low in any cycle.
- `an` is never low during the first `DEAD_CYC` cycles of a slot.

## Test plan
All scenarios use `REFRESH_DIV`=8, `DEAD_CYC`=2, so a frame is 24 cycles.
- **Reset, no load:** hold `rst` 3 cycles then release, no load → `an`=111, `seg`=1111111 throughout; `frame` pulses at cycles 24, 48, 72.
- **Basic display:** load `d0`=1, `d1`=8, `d2`=F, `blank`=000 at cycle 5 → from cycle 24: digit 0 dark for cycles 24–26, `an`=110 and `seg`=1111001 for cycles 27–32; digit 1 shows `an`=101, `seg`=0000000 for cycles 35–40; digit 2 shows `an`=011, `seg`=0001110 for cycles 43–48.
- **No tearing:** with display showing 1/8/F, load `d0`=0, `d1`=0, `d2`=0 at cycle 36 (mid digit 1) → digits 1 and 2 still show 8 and F in that frame; 0/0/0 appears only after the `frame` pulse at cycle 48.
- **Blanking:** load `blank`=010 with digits 3/4/5 → in every frame, `an[1]` stays 1 for the whole digit-1 slot, and `seg`=1111111 during that slot; digits 0 and 2 show 0110000 and 0010010.
- **Load on the boundary edge:** `pend`=1 holding A, then load C in the boundary cycle (`cnt`=7, `idx`=2) → the next frame displays A; the frame after displays C.
- **Reset mid-scan:** assert `rst` 1 cycle while `an`=101 with `load` high in the same cycle → next cycle `an`=111, `seg`=1111111, `frame`=0; no digit lights afterwards (the load was ignored, `pend`=0).
